// File: rtl/mipi_csi_rx_packet_decoder_8b4lane_if.sv
// Byte-stream input and decoded payload/status output bundle for the 4-lane CSI-2 packet decoder.
interface mipi_csi_rx_packet_decoder_8b4lane_if;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned TYPE_W  = 3;
   localparam int unsigned COUNT_W = 16;

   logic                 data_valid_i;
   logic [DATA_W-1:0]    data_i;
   logic                 output_valid_o;
   logic [DATA_W-1:0]    data_o;
   logic [TYPE_W-1:0]    packet_type_o;
   logic                 frame_start_o;
   logic                 frame_end_o;
   logic [COUNT_W-1:0]   line_count_o;
   logic                 error_o;

   modport master (
      output data_valid_i, data_i,
      input  output_valid_o, data_o, packet_type_o, frame_start_o, frame_end_o,
             line_count_o, error_o
   );

   modport slave (
      input  data_valid_i, data_i,
      output output_valid_o, data_o, packet_type_o, frame_start_o, frame_end_o,
             line_count_o, error_o
   );
endinterface

// File: rtl/mipi_csi_rx_packet_decoder_8b4lane.sv
// CSI-2 packet decoder: parses the header word, realigns long-packet payload by 4 bytes,
// and reports frame start/end, line count and truncated packets.
module mipi_csi_rx_packet_decoder_8b4lane (
   input logic clk_i,
   input logic reset_n_i,
   mipi_csi_rx_packet_decoder_8b4lane_if.slave bus
);
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned HALF_W  = 32;
   localparam int unsigned TYPE_W  = 3;
   localparam int unsigned COUNT_W = 16;
   localparam int unsigned DT_W    = 6;

   localparam logic [DT_W-1:0] DT_FS     = 6'h00;
   localparam logic [DT_W-1:0] DT_FE     = 6'h01;
   localparam logic [DT_W-1:0] DT_RAW10  = 6'h2B;
   localparam logic [DT_W-1:0] DT_RAW12  = 6'h2C;
   localparam logic [DT_W-1:0] DT_RAW14  = 6'h2D;
   localparam logic [COUNT_W-1:0] WORD_BYTES = 16'd8;

   typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_DRAIN} state_e;

   state_e               state_q, state_d;
   logic [COUNT_W-1:0]   rem_q, rem_d;
   logic [HALF_W-1:0]    hold_q, hold_d;
   logic                 prev_valid_q, prev_valid_d;
   logic                 out_valid_q, out_valid_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [TYPE_W-1:0]    type_q, type_d;
   logic                 fs_q, fs_d;
   logic                 fe_q, fe_d;
   logic                 err_q, err_d;
   logic [COUNT_W-1:0]   line_q, line_d;

   logic [DT_W-1:0]      hdr_dt;
   logic [COUNT_W-1:0]   hdr_wc;
   logic                 hdr_long;

   assign hdr_dt   = bus.data_i[5:0];
   assign hdr_wc   = bus.data_i[23:8];
   assign hdr_long = (hdr_dt == DT_RAW10) || (hdr_dt == DT_RAW12) || (hdr_dt == DT_RAW14);

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      hold_d       = hold_q;
      prev_valid_d = bus.data_valid_i;
      out_valid_d  = 1'b0;
      data_d       = data_q;
      type_d       = type_q;
      fs_d         = 1'b0;
      fe_d         = 1'b0;
      err_d        = 1'b0;
      line_d       = line_q;

      unique case (state_q)
         ST_IDLE: begin
            // A header is only trusted after a low cycle, which also covers reset mid-burst.
            if (bus.data_valid_i && !prev_valid_q) begin
               if (hdr_long && (hdr_wc != '0)) begin
                  type_d  = bus.data_i[2:0];
                  rem_d   = hdr_wc;
                  hold_d  = bus.data_i[63:32];
                  state_d = ST_PAYLOAD;
               end else begin
                  if (hdr_dt == DT_FS) begin
                     fs_d   = 1'b1;
                     line_d = '0;
                  end else if (hdr_dt == DT_FE) begin
                     fe_d = 1'b1;
                  end
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_PAYLOAD: begin
            if (!bus.data_valid_i) begin
               err_d   = 1'b1;
               rem_d   = '0;
               state_d = ST_IDLE;
            end else begin
               out_valid_d = 1'b1;
               data_d      = {bus.data_i[31:0], hold_q};
               hold_d      = bus.data_i[63:32];
               if (rem_q <= WORD_BYTES) begin
                  rem_d   = '0;
                  line_d  = COUNT_W'(line_q + 16'd1);
                  state_d = ST_DRAIN;
               end else begin
                  rem_d = COUNT_W'(rem_q - WORD_BYTES);
               end
            end
         end
         ST_DRAIN: begin
            if (!bus.data_valid_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= ST_IDLE;
         rem_q        <= '0;
         hold_q       <= '0;
         prev_valid_q <= 1'b1;
         out_valid_q  <= 1'b0;
         data_q       <= '0;
         type_q       <= '0;
         fs_q         <= 1'b0;
         fe_q         <= 1'b0;
         err_q        <= 1'b0;
         line_q       <= '0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         hold_q       <= hold_d;
         prev_valid_q <= prev_valid_d;
         out_valid_q  <= out_valid_d;
         data_q       <= data_d;
         type_q       <= type_d;
         fs_q         <= fs_d;
         fe_q         <= fe_d;
         err_q        <= err_d;
         line_q       <= line_d;
      end
   end

   assign bus.output_valid_o = out_valid_q;
   assign bus.data_o         = data_q;
   assign bus.packet_type_o  = type_q;
   assign bus.frame_start_o  = fs_q;
   assign bus.frame_end_o    = fe_q;
   assign bus.line_count_o   = line_q;
   assign bus.error_o        = err_q;
endmodule
